// File: rtl/answer_pkg.sv
// Shared answer-path definitions: mode encodings, reveal FSM states and the
// default answer geometry used by the generator, this block and the display mux.
package answer_pkg;

    localparam int DEFAULT_DIGITS = 4;
    localparam int DEFAULT_DW     = 4;

    localparam logic [1:0] MODE_HIDE     = 2'd0;
    localparam logic [1:0] MODE_SHOW_ALL = 2'd1;
    localparam logic [1:0] MODE_REVEAL   = 2'd2;
    localparam logic [1:0] MODE_BLINK    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REVEAL,
        ST_SHOW,
        ST_BLINK
    } state_t;

endpackage

// File: rtl/step_tick.sv
// Free-running prescaler: counts 0..last, wraps, and strobes for one cycle on
// the terminal count while enabled.
module step_tick #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] last,
    output logic          strobe
);

    logic [CW-1:0] cnt;

    assign strobe = enable && (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == last) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/answer_reveal.sv
// Snapshots the secret answer on start and presents it to the 7-segment path
// as hidden, fully shown, revealed digit by digit, or blinking.
module answer_reveal
    import answer_pkg::*;
#(
    parameter int DIGITS    = DEFAULT_DIGITS,
    parameter int DW        = DEFAULT_DW,
    parameter int TICK_DIV  = 25000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [1:0]           mode,
    input  logic [DIGITS*DW-1:0] digits_in,
    output logic [DIGITS*DW-1:0] digits_out,
    output logic [DIGITS-1:0]    blank,
    output logic                 busy,
    output logic                 done
);

    localparam int MAXDIV = (TICK_DIV > BLINK_DIV) ? TICK_DIV : BLINK_DIV;
    localparam int CW     = $clog2(MAXDIV);
    localparam int CNTW   = $clog2(DIGITS + 1);

    state_t                 state;
    logic [DIGITS*DW-1:0]   snapshot;
    logic [CNTW-1:0]        count;
    logic [CNTW-1:0]        count_inc;
    logic                   phase;
    logic                   step;
    logic [CW-1:0]          tick_last;

    function automatic logic [DIGITS-1:0] reveal_blank(input logic [CNTW-1:0] n);
        for (int k = 0; k < DIGITS; k++) begin
            reveal_blank[k] = !(k < int'(n));
        end
    endfunction

    function automatic logic [DIGITS*DW-1:0] mask_digits(input logic [DIGITS*DW-1:0] d,
                                                          input logic [DIGITS-1:0]    bl);
        mask_digits = d;
        for (int k = 0; k < DIGITS; k++) begin
            if (bl[k]) mask_digits[k*DW +: DW] = '0;
        end
    endfunction

    assign count_inc = count + CNTW'(1);
    assign tick_last = (state == ST_BLINK) ? CW'(BLINK_DIV - 1) : CW'(TICK_DIV - 1);

    // One prescaler serves both timed states; its period follows the current state.
    step_tick #(.CW(CW)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear || start),
        .enable ((state == ST_REVEAL) || (state == ST_BLINK)),
        .last   (tick_last),
        .strobe (step)
    );

    // Outputs are computed from the values being written this edge so they
    // track the new state without an extra cycle of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            snapshot   <= '0;
            count      <= '0;
            phase      <= 1'b0;
            digits_out <= '0;
            blank      <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state      <= ST_IDLE;
                count      <= '0;
                phase      <= 1'b0;
                digits_out <= '0;
                blank      <= '1;
                busy       <= 1'b0;
            end else if (start) begin
                snapshot <= digits_in;
                count    <= '0;
                phase    <= 1'b0;
                case (mode)
                    MODE_SHOW_ALL: begin
                        state      <= ST_SHOW;
                        digits_out <= digits_in;
                        blank      <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                    MODE_REVEAL: begin
                        state      <= ST_REVEAL;
                        digits_out <= '0;
                        blank      <= '1;
                        busy       <= 1'b1;
                    end
                    MODE_BLINK: begin
                        state      <= ST_BLINK;
                        phase      <= 1'b1;
                        digits_out <= digits_in;
                        blank      <= '0;
                        busy       <= 1'b1;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        digits_out <= '0;
                        blank      <= '1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    ST_REVEAL: begin
                        if (step && (count < CNTW'(DIGITS))) begin
                            count      <= count_inc;
                            blank      <= reveal_blank(count_inc);
                            digits_out <= mask_digits(snapshot, reveal_blank(count_inc));
                            if (count_inc == CNTW'(DIGITS)) begin
                                state <= ST_SHOW;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_BLINK: begin
                        if (step) begin
                            phase      <= !phase;
                            blank      <= phase ? '1 : '0;
                            digits_out <= phase ? '0 : snapshot;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_answer_reveal.sv
// Directed scoreboard bench for answer_reveal: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares one entry per clock edge.
module tb_answer_reveal;
    import answer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [1:0]  mode;
    logic [15:0] digits_in;
    logic [15:0] digits_out;
    logic [3:0]  blank;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] dout;
        logic [3:0]  blank;
        logic        busy;
        logic        done;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    answer_reveal #(
        .DIGITS    (4),
        .DW        (4),
        .TICK_DIV  (4),
        .BLINK_DIV (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear      (clear),
        .mode       (mode),
        .digits_in  (digits_in),
        .digits_out (digits_out),
        .blank      (blank),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mask16(input logic [15:0] d, input logic [3:0] bl);
        logic [15:0] r;
        r = d;
        if (bl[0]) r[3:0]   = 4'h0;
        if (bl[1]) r[7:4]   = 4'h0;
        if (bl[2]) r[11:8]  = 4'h0;
        if (bl[3]) r[15:12] = 4'h0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] edout, input logic [3:0] eblank,
                            input logic ebusy, input logic edone);
        checkOutput({tag, ".digits_out"}, 32'(digits_out), 32'(edout));
        checkOutput({tag, ".blank"}, 32'(blank), 32'(eblank));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(ebusy));
        checkOutput({tag, ".done"}, 32'(done), 32'(edone));
    endtask

    task automatic applyStimulus(input logic st, input logic cl, input logic [1:0] md,
                                 input logic [15:0] din, input logic [15:0] edout,
                                 input logic [3:0] eblank, input logic ebusy,
                                 input logic edone, input string tag);
        exp_t e;
        @(negedge clk);
        start     = st;
        clear     = cl;
        mode      = md;
        digits_in = din;
        e.dout  = edout;
        e.blank = eblank;
        e.busy  = ebusy;
        e.done  = edone;
        e.tag   = tag;
        q.push_back(e);
    endtask

    // Monitor: one expected entry per active edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checkAll(e.tag, e.dout, e.blank, e.busy, e.done);
            end
        end
    end

    initial begin
        logic [3:0] bl;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        mode      = MODE_HIDE;
        digits_in = 16'h5382;

        repeat (2) @(negedge clk);
        checkAll("reset_hold", 16'h0000, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(0, 0, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0, "reset_release");
        applyStimulus(0, 0, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0, "reset_idle");

        applyStimulus(1, 0, MODE_SHOW_ALL, 16'h5382, 16'h5382, 4'h0, 0, 1, "show_start");
        applyStimulus(0, 0, MODE_HIDE, 16'h1111, 16'h5382, 4'h0, 0, 0, "show_hold1");
        applyStimulus(0, 0, MODE_HIDE, 16'h1111, 16'h5382, 4'h0, 0, 0, "show_hold2");

        applyStimulus(1, 0, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 1, "hide_start");
        applyStimulus(0, 0, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0, "hide_idle");

        applyStimulus(1, 0, MODE_REVEAL, 16'h5382, 16'h0000, 4'hF, 1, 0, "reveal_start");
        for (int c = 1; c <= 16; c++) begin
            bl = 4'b1111 << (c / 4);
            applyStimulus(0, 0, MODE_HIDE, 16'h5382, mask16(16'h5382, bl), bl,
                          c < 16, c == 16, $sformatf("reveal_e%0d", c));
        end
        applyStimulus(0, 0, MODE_HIDE, 16'h5382, 16'h5382, 4'h0, 0, 0, "reveal_show");

        applyStimulus(1, 0, MODE_BLINK, 16'h5382, 16'h5382, 4'h0, 1, 0, "blink_start");
        for (int c = 1; c < 24; c++) begin
            bl = (((c / 3) % 2) == 0) ? 4'h0 : 4'hF;
            applyStimulus(0, 0, MODE_HIDE, 16'h5382, mask16(16'h5382, bl), bl, 1, 0,
                          $sformatf("blink_e%0d", c));
        end
        applyStimulus(0, 1, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0, "blink_clear");

        applyStimulus(1, 0, MODE_REVEAL, 16'h5382, 16'h0000, 4'hF, 1, 0, "abort_start");
        for (int c = 1; c <= 5; c++) begin
            bl = 4'b1111 << (c / 4);
            applyStimulus(0, 0, MODE_HIDE, 16'h5382, mask16(16'h5382, bl), bl, 1, 0,
                          $sformatf("abort_e%0d", c));
        end
        applyStimulus(0, 1, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0, "abort_clear");
        for (int c = 7; c <= 9; c++) begin
            applyStimulus(0, 0, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0,
                          $sformatf("abort_idle_e%0d", c));
        end
        applyStimulus(1, 0, MODE_REVEAL, 16'h1234, 16'h0000, 4'hF, 1, 0, "restart_start");
        for (int c = 1; c <= 16; c++) begin
            bl = 4'b1111 << (c / 4);
            applyStimulus(0, 0, MODE_HIDE, 16'h9999, mask16(16'h1234, bl), bl,
                          c < 16, c == 16, $sformatf("restart_e%0d", c));
        end
        applyStimulus(1, 1, MODE_SHOW_ALL, 16'h5382, 16'h0000, 4'hF, 0, 0, "start_and_clear");
        applyStimulus(0, 0, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0, "after_both");

        applyStimulus(1, 0, MODE_REVEAL, 16'h5382, 16'h0000, 4'hF, 1, 0, "arst_start");
        for (int c = 1; c <= 9; c++) begin
            bl = 4'b1111 << (c / 4);
            applyStimulus(0, 0, MODE_HIDE, 16'h5382, mask16(16'h5382, bl), bl, 1, 0,
                          $sformatf("arst_e%0d", c));
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkAll("arst_immediate", 16'h0000, 4'hF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkAll("arst_held", 16'h0000, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(0, 0, MODE_HIDE, 16'h5382, 16'h0000, 4'hF, 0, 0, "arst_release");

        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
